// File: rtl/jt51_phrom_arb.sv
// Round-robin arbiter sharing one registered ROM between NREQ requesters; optional fixed priority for requester 0.
// Latency: req -> gnt 1 cycle, gnt -> rd_valid 1 cycle. One grant per cycle, so requesters hold req until gnt.
module jt51_phrom_arb #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 46,
  parameter int FIX0 = 0,
  parameter int TW   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rd_valid,
  output logic [TW-1:0]        rd_tag,
  output logic [DW-1:0]        rd_data,
  output logic [AW-1:0]        rom_addr,
  input  logic [DW-1:0]        rom_data
);

  logic [TW-1:0] ptr;
  logic [TW-1:0] ptr_nxt;
  logic [TW-1:0] win;
  logic [TW-1:0] cand;
  logic [TW-1:0] gnt_idx;
  logic          found;
  logic          fixed_win;

  always_comb begin
    found     = 1'b0;
    win       = '0;
    cand      = '0;
    fixed_win = (FIX0 != 0) && req[0];
    for (int k = 0; k < NREQ; k++) begin
      cand = TW'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    if (fixed_win) begin
      found = 1'b1;
      win   = '0;
    end
    // Fixed-priority grants to requester 0 leave the rotation untouched.
    ptr_nxt = ptr;
    if (found && !fixed_win)
      ptr_nxt = (win == TW'(NREQ - 1)) ? '0 : win + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt      <= '0;
      gnt_idx  <= '0;
      rd_valid <= '0;
      rd_tag   <= '0;
      rom_addr <= '0;
      ptr      <= '0;
    end else begin
      gnt <= found ? (NREQ'(1) << win) : '0;
      if (found) begin
        gnt_idx  <= win;
        rom_addr <= req_addr[int'(win)*AW +: AW];
      end
      ptr      <= ptr_nxt;
      // The ROM samples rom_addr on this same edge, so its data lines up with rd_valid.
      rd_valid <= gnt;
      if (|gnt)
        rd_tag <= gnt_idx;
    end
  end

  assign rd_data = rom_data;

endmodule

// File: tb/tb_jt51_phrom_arb.sv
// Bench for jt51_phrom_arb: two instances (FIX0=0 and FIX0=1) on shared stimulus, each checked every cycle
// against a queue-free behavioural model, plus directed literal checks.
module tb_jt51_phrom_arb;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        req;
  logic [19:0]       req_addr;
  logic [1:0][3:0]   gnt_o;
  logic [1:0][3:0]   rdv_o;
  logic [1:0][1:0]   tag_o;
  logic [1:0][45:0]  dat_o;
  logic [1:0][4:0]   ra_o;
  logic [1:0][45:0]  rom_q;

  logic [45:0] rom [32];
  localparam logic [45:0] ROM31 = 46'b1110011011110001111011100111100001110110100111;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  jt51_phrom_arb #(.NREQ(4), .AW(5), .DW(46), .FIX0(0), .TW(2)) u_rr (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr),
    .gnt(gnt_o[0]), .rd_valid(rdv_o[0]), .rd_tag(tag_o[0]), .rd_data(dat_o[0]),
    .rom_addr(ra_o[0]), .rom_data(rom_q[0])
  );

  jt51_phrom_arb #(.NREQ(4), .AW(5), .DW(46), .FIX0(1), .TW(2)) u_fx (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr),
    .gnt(gnt_o[1]), .rd_valid(rdv_o[1]), .rd_tag(tag_o[1]), .rd_data(dat_o[1]),
    .rom_addr(ra_o[1]), .rom_data(rom_q[1])
  );

  // ROM with one registered cycle of latency, one copy per instance.
  always @(posedge clk) begin
    rom_q[0] <= rom[ra_o[0]];
    rom_q[1] <= rom[ra_o[1]];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: what each output must be after the most recent edge.
  logic [3:0]  m_gnt  [2];
  logic [4:0]  m_addr [2];
  int          m_ptr  [2];
  logic [3:0]  m_vld  [2];
  int          m_tag  [2];
  logic [45:0] m_dat  [2];
  bit          m_live = 1'b0;

  always @(posedge clk) begin : model
    int w;
    for (int j = 0; j < 2; j++) begin
      if (rst) begin
        m_gnt[j] = 4'b0; m_addr[j] = 5'd0; m_ptr[j] = 0;
        m_vld[j] = 4'b0; m_tag[j] = 0;
      end else begin
        m_vld[j] = m_gnt[j];
        if (m_gnt[j] != 4'b0) begin
          m_tag[j] = $clog2(m_gnt[j]);
          m_dat[j] = rom[m_addr[j]];
        end
        w = -1;
        if (j == 1 && req[0]) w = 0;
        else
          for (int k = 0; k < 4; k++)
            if (w < 0 && req[(m_ptr[j] + k) % 4]) w = (m_ptr[j] + k) % 4;
        if (w >= 0) begin
          m_gnt[j]  = 4'b0001 << w;
          m_addr[j] = req_addr[w*5 +: 5];
          if (!(j == 1 && req[0])) m_ptr[j] = (w + 1) % 4;
        end else begin
          m_gnt[j] = 4'b0;
        end
      end
    end
    if (rst) m_live = 1'b1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      for (int j = 0; j < 2; j++) begin
        chk($sformatf("model_gnt%0d", j), 64'(gnt_o[j]), 64'(m_gnt[j]));
        chk($sformatf("model_rom_addr%0d", j), 64'(ra_o[j]), 64'(m_addr[j]));
        chk($sformatf("model_rd_valid%0d", j), 64'(rdv_o[j]), 64'(m_vld[j]));
        if (m_vld[j] != 4'b0) begin
          chk($sformatf("model_rd_tag%0d", j), 64'(tag_o[j]), 64'(m_tag[j]));
          chk($sformatf("model_rd_data%0d", j), 64'(dat_o[j]), 64'(m_dat[j]));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = {14'($urandom), 32'($urandom)};
    rom[31] = ROM31;
    rst = 1'b1; req = 4'b0; req_addr = '0;
    repeat (2) @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      chk("reset_gnt", 64'(gnt_o[j]), 64'd0);
      chk("reset_rd_valid", 64'(rdv_o[j]), 64'd0);
      chk("reset_rd_tag", 64'(tag_o[j]), 64'd0);
      chk("reset_rom_addr", 64'(ra_o[j]), 64'd0);
    end

    // Single request from requester 1 at address 31.
    rst = 1'b0; req = 4'b0010; req_addr[5 +: 5] = 5'd31;
    @(negedge clk);
    chk("t1_gnt", 64'(gnt_o[0]), 64'b0010);
    chk("t1_rom_addr", 64'(ra_o[0]), 64'd31);
    req = 4'b0;
    @(negedge clk);
    chk("t1_rd_valid", 64'(rdv_o[0]), 64'b0010);
    chk("t1_rd_tag", 64'(tag_o[0]), 64'd1);
    chk("t1_rd_data", 64'(dat_o[0]), 64'(ROM31));

    // All four requesting from a fresh pointer.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t2_gnt", 64'(gnt_o[0]), 64'(4'b0001 << (i % 4)));
      chk("t2_fix_gnt", 64'(gnt_o[1]), 64'b0001);
      if (i >= 1) begin
        chk("t2_rd_valid", 64'(rdv_o[0]), 64'(4'b0001 << ((i - 1) % 4)));
        chk("t2_rd_tag", 64'(tag_o[0]), 64'((i - 1) % 4));
      end
    end

    // Fixed priority, then round-robin over requesters 2 and 3.
    req = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_fix_gnt", 64'(gnt_o[1]), 64'b0001);
    end
    req = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_rr23_gnt", 64'(gnt_o[1]), (i % 2 == 0) ? 64'b0100 : 64'b1000);
    end

    // Requester 2 sweeps all 32 addresses back to back.
    for (int n = 0; n < 34; n++) begin
      @(negedge clk);
      if (n >= 2) begin
        chk("t4_rd_valid", 64'(rdv_o[0]), 64'b0100);
        chk("t4_rd_data", 64'(dat_o[0]), 64'(rom[n - 2]));
      end
      if (n < 32) begin
        req = 4'b0100; req_addr[10 +: 5] = 5'(n);
      end else begin
        req = 4'b0;
      end
    end

    // Reset while grants are in flight.
    for (int i = 0; i < 4; i++) req_addr[i*5 +: 5] = 5'(10 + i);
    req = 4'b1111;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_gnt", 64'(gnt_o[0]), 64'd0);
    chk("t5_rd_valid", 64'(rdv_o[0]), 64'd0);
    chk("t5_rom_addr", 64'(ra_o[0]), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_first_gnt", 64'(gnt_o[0]), 64'b0001);
    chk("t5_first_addr", 64'(ra_o[0]), 64'd10);
    chk("t5_no_rd", 64'(rdv_o[0]), 64'd0);

    // Idle, then requester 3 alone.
    req = 4'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_idle_gnt", 64'(gnt_o[0]), 64'd0);
      chk("t6_idle_addr", 64'(ra_o[0]), 64'd10);
      if (i >= 1) chk("t6_idle_rd", 64'(rdv_o[0]), 64'd0);
    end
    req = 4'b1000;
    @(negedge clk);
    chk("t6_gnt3", 64'(gnt_o[0]), 64'b1000);
    chk("t6_addr3", 64'(ra_o[0]), 64'd13);
    req = 4'b0;

    // Randomized traffic with occasional resets; the model process checks every cycle.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      req      = (c % 3 == 0) ? 4'($urandom) & 4'($urandom) : 4'($urandom);
      req_addr = 20'($urandom);
      rst      = ($urandom_range(0, 63) == 0);
    end
    rst = 1'b0; req = 4'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
